// File: rtl/param_alu_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : param_alu_acc
// Purpose  : Registered ALU with an odd constant operand (C = 2*sel+1), an
//            internal accumulator and valid/ready handshake on both sides.
//            Single-entry output register, 1-cycle latency, full throughput.
// Options  : PARAM_ALU_SATURATE_EN - ADD saturates to all-ones on carry, SUB
//            saturates to zero on borrow (carry flag still reports it).
// Revision : 1.0 - initial release
// ============================================================================
module param_alu_acc #(
    parameter int WIDTH  = 8,   // datapath width, >= 4
    parameter int CSEL_W = 2    // constant-select width, CSEL_W+1 <= WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_acc,
    input  logic [CSEL_W-1:0] in_csel,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_neg,
    output logic [WIDTH-1:0]  acc_value
);

    localparam logic [2:0] C_OP_ADD  = 3'd0;
    localparam logic [2:0] C_OP_SUB  = 3'd1;
    localparam logic [2:0] C_OP_AND  = 3'd2;
    localparam logic [2:0] C_OP_OR   = 3'd3;
    localparam logic [2:0] C_OP_XOR  = 3'd4;
    localparam logic [2:0] C_OP_SHL  = 3'd5;
    localparam logic [2:0] C_OP_SHR  = 3'd6;
    localparam logic [2:0] C_OP_PASS = 3'd7;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_carry;
    logic             r_neg;
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_raw;
    logic             w_carry;
    logic [WIDTH-1:0] w_result;
    logic             w_accept;

    // Handshake: the output register can take a new result when empty or
    // when its current content is being consumed on the same edge.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Operand A: accumulator value from before the edge, so chains work.
    always_comb begin
        w_a = in_acc ? r_acc : in_data;
    end

    // Odd constant 2*sel+1, zero-extended; built by bit placement so the
    // case CSEL_W+1 == WIDTH needs no zero-width replication.
    always_comb begin
        w_c             = '0;
        w_c[CSEL_W:0]   = {in_csel, 1'b1};
    end

    // Extended add/subtract; the top bit is carry-out or borrow.
    always_comb begin
        w_sum  = {1'b0, w_a} + {1'b0, w_c};
        w_diff = {1'b0, w_a} - {1'b0, w_c};
    end

    // Opcode decode producing the unsaturated result and the carry flag.
    always_comb begin
        w_raw   = w_a;
        w_carry = 1'b0;
        case (in_op)
            C_OP_ADD: begin
                w_raw   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            C_OP_SUB: begin
                w_raw   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            C_OP_AND: w_raw = w_a & w_c;
            C_OP_OR:  w_raw = w_a | w_c;
            C_OP_XOR: w_raw = w_a ^ w_c;
            C_OP_SHL: begin
                w_raw   = {w_a[WIDTH-2:0], 1'b0};
                w_carry = w_a[WIDTH-1];
            end
            C_OP_SHR: begin
                w_raw   = {1'b0, w_a[WIDTH-1:1]};
                w_carry = w_a[0];
            end
            C_OP_PASS: w_raw = w_a;
            default: begin
                w_raw   = w_a;
                w_carry = 1'b0;
            end
        endcase
    end

`ifdef PARAM_ALU_SATURATE_EN
    // Clamp overflowing ADD to all-ones and borrowing SUB to zero; the
    // clamped value feeds flags and accumulator alike.
    always_comb begin
        w_result = w_raw;
        if (in_op == C_OP_ADD && w_carry) begin
            w_result = '1;
        end else if (in_op == C_OP_SUB && w_carry) begin
            w_result = '0;
        end
    end
`else
    // Modulo arithmetic: the raw result is final.
    always_comb begin
        w_result = w_raw;
    end
`endif

    // Output register, flags and accumulator. Accept wins over consume so a
    // simultaneous consume+accept leaves valid high with the new result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_result;
            r_zero  <= (w_result == '0);
            r_carry <= w_carry;
            r_neg   <= w_result[WIDTH-1];
            r_acc   <= w_result;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_zero  = r_zero;
    assign out_carry = r_carry;
    assign out_neg   = r_neg;
    assign acc_value = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_param_alu_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_param_alu_acc
// Purpose  : Scoreboard bench for param_alu_acc (WIDTH=8 and WIDTH=16 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_alu_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, in_acc, out_valid, out_ready;
    logic [7:0]  in_data, out_data, acc_value;
    logic [1:0]  in_csel;
    logic [2:0]  in_op;
    logic        out_zero, out_carry, out_neg;

    logic        in_valid16, in_ready16, in_acc16, out_valid16, out_ready16;
    logic [15:0] in_data16, out_data16, acc_value16;
    logic [2:0]  in_csel16;
    logic [2:0]  in_op16;
    logic        out_zero16, out_carry16, out_neg16;

    param_alu_acc #(.WIDTH(8), .CSEL_W(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_acc(in_acc), .in_csel(in_csel), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_carry(out_carry), .out_neg(out_neg),
        .acc_value(acc_value)
    );

    param_alu_acc #(.WIDTH(16), .CSEL_W(3)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .in_acc(in_acc16), .in_csel(in_csel16), .in_op(in_op16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
        .out_zero(out_zero16), .out_carry(out_carry16), .out_neg(out_neg16),
        .acc_value(acc_value16)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  zcn;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor for the 8-bit instance: compare whenever a result is consumed.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result8: got 0x%0h, expected none", out_data);
            end else begin
                e = q8.pop_front();
                check("data8", {24'h0, out_data}, {16'h0, e.d});
                check("flags8_zcn", {29'h0, out_zero, out_carry, out_neg}, {29'h0, e.zcn});
                check("acc8", {24'h0, acc_value}, {16'h0, e.d});
            end
        end
    end

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result16: got 0x%0h, expected none", out_data16);
            end else begin
                e = q16.pop_front();
                check("data16", {16'h0, out_data16}, {16'h0, e.d});
                check("flags16_zcn", {29'h0, out_zero16, out_carry16, out_neg16}, {29'h0, e.zcn});
            end
        end
    end

    // Issue one command to the 8-bit instance; expected value goes to the queue.
    task automatic send8(input logic [7:0] a, input logic acc, input logic [1:0] cs,
                         input logic [2:0] op, input logic [7:0] d, input logic [2:0] zcn);
        in_valid = 1'b1; in_data = a; in_acc = acc; in_csel = cs; in_op = op;
        #1;
        check("in_ready8", {31'h0, in_ready}, 32'h1);
        q8.push_back('{d: {8'h0, d}, zcn: zcn});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("latency_valid8", {31'h0, out_valid}, 32'h1);
    endtask

    task automatic send16(input logic [15:0] a, input logic [2:0] cs, input logic [2:0] op,
                          input logic [15:0] d, input logic [2:0] zcn);
        in_valid16 = 1'b1; in_data16 = a; in_acc16 = 1'b0; in_csel16 = cs; in_op16 = op;
        #1;
        q16.push_back('{d: d, zcn: zcn});
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        check("latency_valid16", {31'h0, out_valid16}, 32'h1);
    endtask

    // Assert reset asynchronously, check cleared state, release.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data", {24'h0, out_data}, 32'h0);
        check("rst_flags", {29'h0, out_zero, out_carry, out_neg}, 32'h0);
        check("rst_acc", {24'h0, acc_value}, 32'h0);
        q8.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    endtask

    logic [7:0] ops_exp [8] = '{8'h15, 8'h0B, 8'h00, 8'h15, 8'h15, 8'h20, 8'h08, 8'h10};
    logic [2:0] ops_zcn [8] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_data = '0; in_acc = 1'b0;
        in_csel = '0; in_op = '0;
        out_ready16 = 1'b1; in_valid16 = 1'b0; in_data16 = '0; in_acc16 = 1'b0;
        in_csel16 = '0; in_op16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("init_valid", {31'h0, out_valid}, 32'h0);
        check("init_flags", {29'h0, out_zero, out_carry, out_neg}, 32'h0);
        check("init_acc", {24'h0, acc_value}, 32'h0);
        reset = 1'b0;
        #1;
        check("init_in_ready", {31'h0, in_ready}, 32'h1);

        // All opcodes, A=0x10, C=5, back to back.
        for (int i = 0; i < 8; i++) begin
            send8(8'h10, 1'b0, 2'd2, 3'(i), ops_exp[i], ops_zcn[i]);
        end

        // Wrap / borrow.
`ifdef PARAM_ALU_SATURATE_EN
        send8(8'hFE, 1'b0, 2'd1, 3'd0, 8'hFF, 3'b011);
        send8(8'h02, 1'b0, 2'd1, 3'd1, 8'h00, 3'b110);
        send8(8'hFF, 1'b0, 2'd0, 3'd0, 8'hFF, 3'b011);
`else
        send8(8'hFE, 1'b0, 2'd1, 3'd0, 8'h01, 3'b010);
        send8(8'h02, 1'b0, 2'd1, 3'd1, 8'hFF, 3'b011);
        send8(8'hFF, 1'b0, 2'd0, 3'd0, 8'h00, 3'b110);
`endif
        // Shift-out bits and a negative logic result.
        send8(8'h81, 1'b0, 2'd0, 3'd5, 8'h02, 3'b010);
        send8(8'h01, 1'b0, 2'd0, 3'd6, 8'h00, 3'b110);
        send8(8'hF0, 1'b0, 2'd3, 3'd4, 8'hF7, 3'b001);

        // Accumulate chain from a fresh reset.
        @(posedge clk); #1;
        do_reset();
        send8(8'h00, 1'b1, 2'd3, 3'd0, 8'd7,  3'b000);
        send8(8'h00, 1'b1, 2'd3, 3'd0, 8'd14, 3'b000);
        send8(8'h00, 1'b1, 2'd3, 3'd0, 8'd21, 3'b000);
        send8(8'h00, 1'b1, 2'd3, 3'd0, 8'd28, 3'b000);
        @(negedge clk);
        check("acc_chain", {24'h0, acc_value}, 32'd28);
        @(posedge clk); #1;

        // Backpressure: hold a result, offer a command for 3 cycles.
        out_ready = 1'b0;
        send8(8'h42, 1'b0, 2'd0, 3'd7, 8'h42, 3'b000);
        in_valid = 1'b1; in_data = 8'h99; in_acc = 1'b1; in_csel = 2'd0; in_op = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_in_ready", {31'h0, in_ready}, 32'h0);
            check("stall_data", {24'h0, out_data}, 32'h42);
            check("stall_acc", {24'h0, acc_value}, 32'h42);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'h0, in_ready}, 32'h1);
        q8.push_back('{d: 16'h0043, zcn: 3'b000});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("no_bubble_valid", {31'h0, out_valid}, 32'h1);
        @(posedge clk); #1;

        // Reset while a result is stalled.
        out_ready = 1'b0;
        send8(8'h10, 1'b0, 2'd2, 3'd0, 8'h15, 3'b000);
        @(posedge clk); #1;
        do_reset();

        // Wider build.
`ifdef PARAM_ALU_SATURATE_EN
        send16(16'h0000, 3'd7, 3'd1, 16'h0000, 3'b110);
        send16(16'hFFFF, 3'd0, 3'd0, 16'hFFFF, 3'b011);
`else
        send16(16'h0000, 3'd7, 3'd1, 16'hFFF1, 3'b011);
        send16(16'hFFFF, 3'd0, 3'd0, 16'h0000, 3'b110);
`endif
        send16(16'h8000, 3'd5, 3'd3, 16'h800B, 3'b001);

        repeat (3) @(posedge clk);
        #1;
        check("q8_drained", q8.size(), 32'h0);
        check("q16_drained", q16.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
